// File: rtl/sap_pkg.sv
// Shared SAP definitions: loader FSM states, RAM geometry and loader error codes.
package sap_pkg;

  localparam int unsigned RAM_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CKSUM,
    VERIFY,
    CHECK,
    DONE
  } loader_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_STREAM   = 2'b01;
  localparam logic [1:0] ERR_READBACK = 2'b10;

endpackage

// File: rtl/ram_loader.sv
// Streams 16 program bytes plus a checksum into the SAP RAM, then reads the image back
// through the synchronous read port and confirms it against the checksum.
module ram_loader
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error_code
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] vcount;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] checksum;
  logic [DATA_WIDTH-1:0] sum_plus_in;
  logic [DATA_WIDTH-1:0] sum_plus_rd;
  logic                  accept;

  always_comb begin
    sum_plus_in = DATA_WIDTH'(sum + in_data);
    sum_plus_rd = DATA_WIDTH'(sum + ram_rdata);
    accept      = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      vcount     <= '0;
      sum        <= '0;
      checksum   <= '0;
      in_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error_code <= ERR_NONE;
    end else begin
      // Write strobe is a single-cycle pulse per accepted byte.
      ram_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= WRITE;
            count      <= '0;
            sum        <= '0;
            error_code <= ERR_NONE;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        WRITE: begin
          if (accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= count;
            ram_wdata <= in_data;
            sum       <= sum_plus_in;
            count     <= count + ADDR_WIDTH'(1);
            if (count == LAST_ADDR) state <= CKSUM;
          end
        end
        CKSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (sum_plus_in == '0) begin
              sum      <= '0;
              checksum <= in_data;
              vcount   <= '0;
              ram_addr <= '0;
              state    <= VERIFY;
            end else begin
              error_code <= ERR_STREAM;
              cpu_hold   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        VERIFY: begin
          // Read data trails the address by one cycle, so the first VERIFY cycle adds nothing.
          if (vcount != '0) sum <= sum_plus_rd;
          if (vcount == LAST_ADDR) begin
            state <= CHECK;
          end else begin
            vcount   <= vcount + ADDR_WIDTH'(1);
            ram_addr <= vcount + ADDR_WIDTH'(1);
          end
        end
        CHECK: begin
          if (DATA_WIDTH'(sum_plus_rd + checksum) != '0) error_code <= ERR_READBACK;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
